// File: rtl/ppa_chunk_serial_adder.sv
// Digit-serial add/subtract: CHUNK bits per cycle through a generate/propagate
// prefix chain, with the inter-chunk carry held in a register.
module ppa_chunk_serial_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0]    LAST_CNT   = CW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;

   logic [31:0]      base_s;
   logic [CHUNK-1:0] ca_s, cb_s, p_s, g_s, cs_s;
   logic [CHUNK:0]   c_s;

   // Grey-cell chain: c[0] is the seed (carry reg as g_lsb, p_lsb = 0).
   function automatic logic [CHUNK:0] prefix_carry(input logic [CHUNK-1:0] p,
                                                   input logic [CHUNK-1:0] g,
                                                   input logic             c0);
      logic [CHUNK:0] c;
      c[0] = c0;
      for (int i = 0; i < CHUNK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return c;
   endfunction

   // Current chunk: pre-processing, carry chain and post-processing.
   always_comb begin
      base_s = 32'(cnt_q) * 32'(CHUNK);
      ca_s   = CHUNK'(a_q >> base_s);
      cb_s   = CHUNK'(b_q >> base_s);
      p_s    = ca_s ^ cb_s;
      g_s    = ca_s & cb_s;
      c_s    = prefix_carry(p_s, g_s, carry_q);
      cs_s   = p_s ^ c_s[CHUNK-1:0];
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{op_sub}};
               carry_d = cin;
               cnt_d   = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_d   = (sum_q & ~(CHUNK_MASK << base_s)) | (WIDTH'(cs_s) << base_s);
            carry_d = c_s[CHUNK];
            if (cnt_q == LAST_CNT) begin
               cout_d  = c_s[CHUNK];
               ovf_d   = c_s[CHUNK] ^ c_s[CHUNK-1];
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign in_ready  = rst_n & (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ppa_chunk_serial_adder.sv
// Scoreboard bench: WIDTH=16 with CHUNK 1, 4 and 16 instances driven in parallel.
module tb_ppa_chunk_serial_adder;
   localparam int W = 16;

   logic clk = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   localparam int NDIR = 5;
   logic [W-1:0] dir_a   [NDIR] = '{16'hFFFF, 16'h0005, 16'h8000, 16'hFFFF, 16'h7FFF};
   logic [W-1:0] dir_b   [NDIR] = '{16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'h0001};
   logic         dir_cin [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic         dir_sub [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
      localparam int NC = W / CH;

      logic         rst_n, in_valid, in_ready, op_sub, cin;
      logic         out_valid, out_ready, cout, ovf;
      logic [W-1:0] a, b, sum;
      logic [W+1:0] exp_q [$];
      logic [W+1:0] e;
      bit           done = 1'b0;

      ppa_chunk_serial_adder #(.WIDTH(W), .CHUNK(CH)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .op_sub    (op_sub),
         .a         (a),
         .b         (b),
         .cin       (cin),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .sum       (sum),
         .cout      (cout),
         .ovf       (ovf)
      );

      function automatic string tg(input string s);
         return $sformatf("c%0d_%s", CH, s);
      endfunction

      // Result consumed on the next edge: compare against the oldest expectation.
      always @(negedge clk) begin
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk(tg("unexpected_result"), 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk(tg("sum"),  32'(sum),  32'(e[W-1:0]));
               chk(tg("cout"), 32'(cout), 32'(e[W]));
               chk(tg("ovf"),  32'(ovf),  32'(e[W+1]));
            end
         end
      end

      task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input logic ts, input bit expect_res);
         int           g;
         logic [W-1:0] bb;
         logic [W:0]   full;
         logic         ov;
         g = 0;
         while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
         end
         chk(tg("in_ready_wait"), 32'(in_ready), 32'(1));
         a = ta; b = tb_v; cin = tc; op_sub = ts; in_valid = 1'b1;
         if (expect_res) begin
            bb   = ts ? ~tb_v : tb_v;
            full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, tc};
            ov   = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
            exp_q.push_back({ov, full[W], full[W-1:0]});
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (expect_res) begin
            g = 0;
            while (!out_valid && g < 200) begin
               @(posedge clk); #1;
               g++;
            end
            chk(tg("latency"), 32'(g), 32'(NC));
         end
      endtask

      task automatic drain(input bit rnd);
         int g;
         g = 0;
         while (out_valid && g < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            g++;
         end
         out_ready = 1'b0;
         chk(tg("drain"), 32'(out_valid), 32'(0));
      endtask

      initial begin
         rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
         op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
         repeat (2) @(posedge clk);
         #1;
         chk(tg("rst_out_valid"), 32'(out_valid), 32'(0));
         chk(tg("rst_in_ready"),  32'(in_ready),  32'(0));
         chk(tg("rst_sum"),       32'(sum),       32'(0));
         chk(tg("rst_cout"),      32'(cout),      32'(0));
         chk(tg("rst_ovf"),       32'(ovf),       32'(0));
         rst_n = 1'b1;
         #1;
         chk(tg("idle_in_ready"), 32'(in_ready), 32'(1));

         for (int i = 0; i < NDIR; i++) begin
            issue(dir_a[i], dir_b[i], dir_cin[i], dir_sub[i], 1'b1);
            drain(1'b0);
         end

         // Backpressure: result held, new operands ignored.
         issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            op_sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk(tg("bp_out_valid"), 32'(out_valid), 32'(1));
            chk(tg("bp_in_ready"),  32'(in_ready),  32'(0));
            chk(tg("bp_sum"),       32'(sum),       32'(16'h5555));
            chk(tg("bp_cout"),      32'(cout),      32'(0));
            chk(tg("bp_ovf"),       32'(ovf),       32'(0));
         end
         in_valid = 1'b0; out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk(tg("bp_rel_out_valid"), 32'(out_valid), 32'(0));
         chk(tg("bp_rel_in_ready"),  32'(in_ready),  32'(1));
         repeat (NC + 3) @(posedge clk);
         #1;
         chk(tg("bp_no_phantom"), 32'(out_valid), 32'(0));

         // Reset in the middle of an operation.
         issue(16'hABCD, 16'h1357, 1'b1, 1'b0, 1'b0);
         repeat ((NC > 2) ? 2 : 0) @(posedge clk);
         #1;
         rst_n = 1'b0;
         @(posedge clk); #1;
         chk(tg("mr_out_valid"), 32'(out_valid), 32'(0));
         chk(tg("mr_sum"),       32'(sum),       32'(0));
         chk(tg("mr_cout"),      32'(cout),      32'(0));
         chk(tg("mr_in_ready"),  32'(in_ready),  32'(0));
         rst_n = 1'b1;
         #1;
         chk(tg("mr_idle"), 32'(in_ready), 32'(1));
         out_ready = 1'b1;
         repeat (NC + 3) @(posedge clk);
         #1;
         out_ready = 1'b0;
         chk(tg("mr_no_result"), 32'(out_valid), 32'(0));

         for (int n = 0; n < 1000; n++) begin
            issue(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1);
            drain(1'b1);
         end
         chk(tg("queue_empty"), 32'(exp_q.size()), 32'(0));
         done = 1'b1;
      end
   end

   initial begin
      int g;
      g = 0;
      while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done) && g < 95000) begin
         @(posedge clk);
         g++;
      end
      chk("all_done", 32'(g_dut[0].done && g_dut[1].done && g_dut[2].done), 32'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ppa_chunk_serial_adder.md
Name: ppa_chunk_serial_adder

Overview:
Parametrised, digit-serial successor to the 4-bit ripple-carry prefix adder. Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. Each chunk uses the same pre / grey-cell / post generate-propagate structure, so datapath area scales with CHUNK rather than WIDTH. Operands enter and results leave through valid/ready handshakes, for multi-cycle arithmetic in area-constrained datapaths.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (derived, localparam), WIDTH/CHUNK, cycles per operation.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  operand request.
in_ready  output  1  block can accept operands.
op_sub  input  1  0 = a+b+cin; 1 = a+~b+cin (cin=1 gives a-b).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in to bit 0.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry out of bit WIDTH-1; for subtraction 1 = no borrow.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: clk and rst_n are one clock with a synchronous, active-low reset.
  - While rst_n=0 at a rising edge, the block loads: state=IDLE, chunk counter=0, carry reg=0, out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset has priority over every other event, including mid-RUN. A reset during RUN discards the operation and produces no out_valid.
- FSM, three states:
  - IDLE: in_ready=1, out_valid=0. If in_valid=1:
    - latch a into a_reg, b^{WIDTH{op_sub}} into b_reg, cin into the carry reg;
    - clear the counter; go to RUN.
    - Inputs are sampled only on this accept edge.
  - RUN: in_ready=0, out_valid=0. Each cycle, with k = counter:
    - compute chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) = a_reg chunk + b_reg chunk + carry;
    - write that chunk of the sum reg; carry reg <= chunk carry-out; counter++.
    - On the edge where k = NCHUNK-1: also latch cout = final carry and ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - sum, cout, ovf are held stable until the out_valid && out_ready edge, then go to IDLE.
    - in_valid is ignored in DONE.
- Chunk datapath:
  - per bit: p = a^b, g = a&b;
  - serial prefix (grey cells) seeded with the carry reg as g_lsb and p_lsb = 0;
  - sum bit = p XOR incoming carry.
  - Purely combinational within the cycle; no path spans chunks except through the carry register.
- Timing:
  - Latency: operands accepted at edge t; out_valid is high from edge t+NCHUNK.
  - Minimum issue interval with out_ready tied high: NCHUNK+2 cycles.
- Sum register contents:
  - Chunks not yet written in RUN hold their previous values.
  - sum is only defined while out_valid=1.
- Counter width: max(1, $clog2(NCHUNK)).
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts exactly one cycle; latency 1.
- Carry propagation across every chunk boundary is exact, including all-ones propagate chains.
- No wrap or overflow of the counter: it is cleared on accept and stops at NCHUNK-1.

Test Plan:
1. WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, op_sub=0 -> accept at edge t; out_valid at t+4; sum=0x0000, cout=1, ovf=0.
2. Subtract, WIDTH=16, CHUNK=4: a=0x0005, b=0x0007, op_sub=1, cin=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001, op_sub=1, cin=1 -> sum=0x7FFF, cout=1, ovf=1.
3. Full propagate chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Also a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
4. Backpressure:
   - hold out_ready=0 for 6 cycles in DONE -> out_valid stays 1; sum/cout/ovf unchanged; in_ready=0;
   - in_valid pulses with new operands are ignored;
   - raise out_ready -> IDLE next edge, in_ready=1.
5. Reset mid-RUN: drop rst_n for one edge after 2 chunks -> next cycle state=IDLE, out_valid=0, sum=0, in_ready=1 once rst_n=1; the aborted result never appears.
6. Parametric sweep: CHUNK in {1,4,16} with WIDTH=16.
   - Latency equals 16, 4, 1 respectively.
   - 1000 random a/b/cin/op_sub vectors match the reference model {cout,sum} = a + (op_sub ? ~b : b) + cin, with ovf checked.
